rtc_bus_arbiter: RTL



---
 rtl/rtc_bus_pkg.sv | 32 +++
 rtl/rtc_bus_arbiter_if.sv | 34 +++
 rtl/rtc_bus_arbiter_rr_arbiter.sv | 34 +++
 rtl/rtc_bus_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC parallel-bus arbiter: FSM states,
// idle bus levels, the RTC control register map and default phase timing.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ALATCH,
        S_STROBE,
        S_HOLD,
        S_GAP
    } state_e;

    localparam logic       IDLE_AD   = 1'b1;
    localparam logic       IDLE_CS   = 1'b1;
    localparam logic       IDLE_WR   = 1'b1;
    localparam logic       IDLE_RD   = 1'b1;
    localparam logic       IDLE_OE   = 1'b0;
    localparam logic [7:0] IDLE_DATA = 8'h00;

    // RTC control register and its mode bits
    localparam logic [7:0] REG_CTRL    = 8'h00;
    localparam int         CTRL_CHRONO = 3;
    localparam int         CTRL_FORMAT = 4;
    localparam int         CTRL_LOCK   = 5;

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 4;
    localparam int T_HOLD_DEF  = 2;
    localparam int T_GAP_DEF   = 3;

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Requester-side handshake plus the RTC pad-side bus signals of the arbiter.
// The arbiter takes the master modport; requesters and pad logic the slave.
interface rtc_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int GW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   req_we;
    logic [8*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   ack;
    logic [7:0]     rdata;
    logic           busy;
    logic [GW-1:0]  gnt_id;
    logic           ad;
    logic           cs;
    logic           wr;
    logic           rd;
    logic [7:0]     ad_out;
    logic           ad_oe;
    logic [7:0]     ad_in;

    modport master (
        input  req, req_we, req_addr, req_wdata, ad_in,
        output ack, rdata, busy, gnt_id, ad, cs, wr, rd, ad_out, ad_oe
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, ad_in,
        input  ack, rdata, busy, gnt_id, ad, cs, wr, rd, ad_out, ad_oe
    );

endinterface

// File: rtl/rtc_bus_arbiter_rr_arbiter.sv
// Combinational N-way round-robin pick: first set request strictly after
// i_ptr, wrapping around, returned as a one-hot grant and an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        int            v_j;
        logic [IW-1:0] v_idx;
        // NOTE: every output gets a default first so no path leaves a latch.
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        v_j     = 0;
        v_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            v_j   = (int'(i_ptr) + k) % N;
            v_idx = IW'(v_j);
            if (!o_valid && i_req[v_idx]) begin
                o_valid      = 1'b1;
                o_idx        = v_idx;
                o_gnt[v_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Sole master of the multiplexed RTC bus: round-robin grants one requester
// at a time a full address-latch plus data-strobe cycle, then acks it.
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int N       = 4,
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF
) (
    input  logic         i_clock,
    input  logic         i_reset,
    rtc_bus_arbiter_if.master bus
);

    localparam int GW = $clog2(N);

    state_e        r_state;
    logic [7:0]    r_cnt;
    logic [GW-1:0] r_ptr;
    logic [GW-1:0] r_gnt_id;
    logic [N-1:0]  r_gnt_oh;
    logic [N-1:0]  r_ack;
    logic          r_we;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rd_cap;
    logic [7:0]    r_rdata;
    logic          r_busy;
    logic          r_ad;
    logic          r_cs;
    logic          r_wr;
    logic          r_rd;
    logic          r_ad_oe;
    logic [7:0]    r_ad_out;

    logic [N-1:0]  w_gnt;
    logic [GW-1:0] w_idx;
    logic          w_valid;
    logic [7:0]    w_sel_addr;
    logic [7:0]    w_sel_wdata;
    logic          w_sel_we;
    logic          w_last;

    rr_arbiter #(.N(N), .IW(GW)) u_rr (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr  = bus.req_addr[8*i +: 8];
                w_sel_wdata = bus.req_wdata[8*i +: 8];
                w_sel_we    = bus.req_we[i];
            end
        end
    end

    // Terminal count is 1, so a phase parameter of 1 lasts exactly one clock
    assign w_last = (r_cnt == 8'd1);

    // NOTE: all state and outputs are registered with non-blocking assignments
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ptr    <= GW'(N-1);
            r_gnt_id <= '0;
            r_gnt_oh <= '0;
            r_ack    <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rd_cap <= '0;
            r_rdata  <= IDLE_DATA;
            r_busy   <= 1'b0;
            r_ad     <= IDLE_AD;
            r_cs     <= IDLE_CS;
            r_wr     <= IDLE_WR;
            r_rd     <= IDLE_RD;
            r_ad_oe  <= IDLE_OE;
            r_ad_out <= IDLE_DATA;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_state  <= S_ADDR;
                        r_cnt    <= 8'(T_SETUP);
                        r_ptr    <= w_idx;
                        r_gnt_id <= w_idx;
                        r_gnt_oh <= w_gnt;
                        r_we     <= w_sel_we;
                        r_wdata  <= w_sel_wdata;
                        r_busy   <= 1'b1;
                        r_ad_oe  <= 1'b1;
                        r_ad_out <= w_sel_addr;
                    end
                end
                S_ADDR: begin
                    if (w_last) begin
                        r_state <= S_ALATCH;
                        r_ad    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_ALATCH: begin
                    r_state  <= S_STROBE;
                    r_cnt    <= 8'(T_PULSE);
                    r_cs     <= 1'b0;
                    r_wr     <= ~r_we;
                    r_rd     <= r_we;
                    r_ad_oe  <= r_we;
                    r_ad_out <= r_we ? r_wdata : IDLE_DATA;
                end
                S_STROBE: begin
                    if (w_last) begin
                        r_state  <= S_HOLD;
                        r_cnt    <= 8'(T_HOLD);
                        r_cs     <= 1'b1;
                        r_wr     <= 1'b1;
                        r_rd     <= 1'b1;
                        r_rd_cap <= bus.ad_in;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_last) begin
                        r_state  <= S_GAP;
                        r_cnt    <= 8'(T_GAP);
                        r_ack    <= r_gnt_oh;
                        r_rdata  <= r_we ? IDLE_DATA : r_rd_cap;
                        r_ad     <= IDLE_AD;
                        r_cs     <= IDLE_CS;
                        r_wr     <= IDLE_WR;
                        r_rd     <= IDLE_RD;
                        r_ad_oe  <= IDLE_OE;
                        r_ad_out <= IDLE_DATA;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    // Read data is only presented alongside the ack pulse
                    r_rdata <= IDLE_DATA;
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack    = r_ack;
    assign bus.rdata  = r_rdata;
    assign bus.busy   = r_busy;
    assign bus.gnt_id = r_gnt_id;
    assign bus.ad     = r_ad;
    assign bus.cs     = r_cs;
    assign bus.wr     = r_wr;
    assign bus.rd     = r_rd;
    assign bus.ad_out = r_ad_out;
    assign bus.ad_oe  = r_ad_oe;

endmodule
